// File: rtl/veririsc_pkg.sv
// veririsc_pkg: shared VeriRISC opcode and phase constants.
// Opcode constants are common to the ALU and the controller.
// Phase constants name the 8 steps of the instruction cycle.
package veririsc_pkg;

    localparam int OPC_W = 3;
    localparam int PH_W  = 3;

    localparam logic [OPC_W-1:0] OP_HLT = 3'd0;
    localparam logic [OPC_W-1:0] OP_SKZ = 3'd1;
    localparam logic [OPC_W-1:0] OP_ADD = 3'd2;
    localparam logic [OPC_W-1:0] OP_AND = 3'd3;
    localparam logic [OPC_W-1:0] OP_XOR = 3'd4;
    localparam logic [OPC_W-1:0] OP_LDA = 3'd5;
    localparam logic [OPC_W-1:0] OP_STO = 3'd6;
    localparam logic [OPC_W-1:0] OP_JMP = 3'd7;

    typedef enum logic [PH_W-1:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_e;

endpackage

// File: rtl/veririsc_ctrl_if.sv
// veririsc_ctrl_if: opcode/zero inputs and control strobes of the VeriRISC controller.
// master: the controller (consumes opcode/zero, drives the strobes and phase).
// slave:  the datapath side (drives opcode/zero, consumes the strobes).
// VERIRISC_CTRL_RESUME_EN adds the resume request driven by the slave side.
interface veririsc_ctrl_if import veririsc_pkg::*; ();

    logic [OPC_W-1:0] opcode;
    logic             zero;
    logic             sel;
    logic             rd;
    logic             ld_ir;
    logic             inc_pc;
    logic             ld_pc;
    logic             ld_ac;
    logic             wr;
    logic             data_e;
    logic             halt;
    logic [PH_W-1:0]  phase;
`ifdef VERIRISC_CTRL_RESUME_EN
    logic             resume;
`endif

    modport master (
`ifdef VERIRISC_CTRL_RESUME_EN
        input  resume,
`endif
        input  opcode, zero,
        output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
    );

    modport slave (
`ifdef VERIRISC_CTRL_RESUME_EN
        output resume,
`endif
        output opcode, zero,
        input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
    );

endinterface

// File: rtl/veririsc_phase_ctr.sv
// veririsc_phase_ctr: 8-phase instruction-cycle counter with sticky halt.
// Ports: clk, rst (sync, active-high); hlt_i = current opcode is HLT;
//        resume_i (only with VERIRISC_CTRL_RESUME_EN) leaves the halted state;
//        phase_o = current phase; halted_o = halted flag.
module veririsc_phase_ctr import veririsc_pkg::*; (
    input  logic   clk,
    input  logic   rst,
`ifdef VERIRISC_CTRL_RESUME_EN
    input  logic   resume_i,
`endif
    input  logic   hlt_i,
    output phase_e phase_o,
    output logic   halted_o
);

    phase_e phase_q, phase_d;
    logic   halted_q, halted_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= PH_INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // Halting happens on the OP_ADDR edge, so the normal increment lands the
    // phase on OP_FETCH, where it then stays frozen.
    always_comb begin
        phase_d  = phase_e'(phase_q + PH_W'(1));
        halted_d = halted_q;
        if (halted_q) begin
            phase_d = phase_q;
`ifdef VERIRISC_CTRL_RESUME_EN
            if (resume_i) begin
                phase_d  = PH_INST_ADDR;
                halted_d = 1'b0;
            end
`endif
        end else if (phase_q == PH_OP_ADDR && hlt_i) begin
            halted_d = 1'b1;
        end
    end

    assign phase_o  = phase_q;
    assign halted_o = halted_q;

endmodule

// File: rtl/veririsc_ctrl.sv
// veririsc_ctrl: VeriRISC sequencing controller, decodes phase/opcode/zero into strobes.
// Ports: clk, rst (sync, active-high); ctrl_if (master) carries opcode, zero,
//        the strobes sel/rd/ld_ir/inc_pc/ld_pc/ld_ac/wr/data_e, halt and phase.
// Optional: VERIRISC_CTRL_RESUME_EN enables leaving halt via ctrl_if.resume.
module veririsc_ctrl import veririsc_pkg::*; (
    input logic            clk,
    input logic            rst,
    veririsc_ctrl_if.master ctrl_if
);

    phase_e phase;
    logic   halted;
    logic   alu_op;
    logic   is_sto;
    logic   is_jmp;

    veririsc_phase_ctr u_phase_ctr (
        .clk      (clk),
        .rst      (rst),
`ifdef VERIRISC_CTRL_RESUME_EN
        .resume_i (ctrl_if.resume),
`endif
        .hlt_i    (ctrl_if.opcode == OP_HLT),
        .phase_o  (phase),
        .halted_o (halted)
    );

    assign alu_op = ctrl_if.opcode inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};
    assign is_sto = ctrl_if.opcode == OP_STO;
    assign is_jmp = ctrl_if.opcode == OP_JMP;
    assign ctrl_if.phase = phase;

    always_comb begin
        ctrl_if.sel    = 1'b0;
        ctrl_if.rd     = 1'b0;
        ctrl_if.ld_ir  = 1'b0;
        ctrl_if.inc_pc = 1'b0;
        ctrl_if.ld_pc  = 1'b0;
        ctrl_if.ld_ac  = 1'b0;
        ctrl_if.wr     = 1'b0;
        ctrl_if.data_e = 1'b0;
        ctrl_if.halt   = halted;
        if (!halted) begin
            case (phase)
                PH_INST_ADDR: ctrl_if.sel = 1'b1;
                PH_INST_FETCH: begin
                    ctrl_if.sel = 1'b1;
                    ctrl_if.rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    ctrl_if.sel   = 1'b1;
                    ctrl_if.rd    = 1'b1;
                    ctrl_if.ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    ctrl_if.inc_pc = 1'b1;
                    ctrl_if.halt   = ctrl_if.opcode == OP_HLT;
                end
                PH_OP_FETCH: ctrl_if.rd = alu_op;
                PH_ALU_OP: begin
                    ctrl_if.rd     = alu_op;
                    ctrl_if.inc_pc = ctrl_if.opcode == OP_SKZ && ctrl_if.zero;
                    ctrl_if.ld_pc  = is_jmp;
                    ctrl_if.data_e = is_sto;
                end
                PH_STORE: begin
                    ctrl_if.rd     = alu_op;
                    ctrl_if.ld_ac  = alu_op;
                    ctrl_if.ld_pc  = is_jmp;
                    ctrl_if.wr     = is_sto;
                    ctrl_if.data_e = is_sto;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_veririsc_ctrl.sv
// tb_veririsc_ctrl: directed plus random checks of veririsc_ctrl against a table model.
module tb_veririsc_ctrl;

`ifdef VERIRISC_CTRL_RESUME_EN
    localparam bit RES_EN = 1'b1;
`else
    localparam bit RES_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   m_ph = 0;
    bit   m_halt = 1'b0;
    int   wr_seen = 0;

    veririsc_ctrl_if bus ();

    veririsc_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_if (bus)
    );

    always #5 clk = ~clk;

    // {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
    function automatic logic [8:0] ref_out(int ph, int op, bit z, bit h);
        logic alu;
        logic [8:0] v;
        alu = (op >= 2 && op <= 5);
        if (h) return 9'b0_0000_0001;
        v[8] = ph < 4;
        v[7] = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        v[6] = ph == 2 || ph == 3;
        v[5] = ph == 4 || (ph == 6 && op == 1 && z);
        v[4] = (ph == 6 || ph == 7) && op == 7;
        v[3] = ph == 7 && alu;
        v[2] = ph == 7 && op == 6;
        v[1] = (ph == 6 || ph == 7) && op == 6;
        v[0] = ph == 4 && op == 0;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input bit r, input int op, input bit z, input bit res, input bit do_chk);
        logic [8:0] got;
        rst = r;
        bus.opcode = op[2:0];
        bus.zero = z;
`ifdef VERIRISC_CTRL_RESUME_EN
        bus.resume = res;
`endif
        #1;
        got = {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc, bus.ld_ac,
               bus.wr, bus.data_e, bus.halt};
        if (do_chk) begin
            chk("phase", 32'(bus.phase), 32'(m_ph));
            chk($sformatf("strobes ph%0d op%0d z%0d", m_ph, op, z), 32'(got), 32'(ref_out(m_ph, op, z, m_halt)));
        end
        if (bus.wr === 1'b1) wr_seen++;
        @(posedge clk);
        if (r) begin
            m_ph = 0;
            m_halt = 1'b0;
        end else if (m_halt) begin
            if (RES_EN && res) begin
                m_halt = 1'b0;
                m_ph = 0;
            end
        end else begin
            if (m_ph == 4 && op == 0) m_halt = 1'b1;
            m_ph = (m_ph + 1) % 8;
        end
        @(negedge clk);
    endtask

    task automatic run(input int op, input bit z, input int n);
        for (int i = 0; i < n; i++) tick(1'b0, op, z, 1'b0, 1'b1);
    endtask

    initial begin
        bus.opcode = 3'd2;
        bus.zero = 1'b0;
`ifdef VERIRISC_CTRL_RESUME_EN
        bus.resume = 1'b0;
`endif
        @(negedge clk);
        tick(1'b1, 2, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 2, 1'b0, 1'b0, 1'b1);
        chk("reset_sel", 32'(bus.sel), 32'd1);
        chk("reset_phase", 32'(bus.phase), 32'd0);
        run(2, 1'b0, 8);
        run(6, 1'b0, 8);
        run(1, 1'b1, 8);
        run(1, 1'b0, 8);
        run(7, 1'b1, 8);
        run(0, 1'b0, 20);
        chk("halt_phase", 32'(bus.phase), 32'd5);
        chk("halt_flag", 32'(bus.halt), 32'd1);
        tick(1'b1, 0, 1'b0, 1'b0, 1'b1);
        chk("halt_rst_phase", 32'(bus.phase), 32'd0);
        chk("halt_rst_halt", 32'(bus.halt), 32'd0);
        run(2, 1'b0, 8);
        if (RES_EN) begin
            run(0, 1'b1, 10);
            tick(1'b0, 0, 1'b0, 1'b1, 1'b1);
            chk("resume_phase", 32'(bus.phase), 32'd0);
            run(3, 1'b0, 8);
        end
        run(6, 1'b0, 6);
        wr_seen = 0;
        tick(1'b1, 6, 1'b0, 1'b0, 1'b1);
        chk("midrst_phase", 32'(bus.phase), 32'd0);
        run(6, 1'b0, 2);
        chk("midrst_no_wr", 32'(wr_seen), 32'd0);
        for (int i = 0; i < 600; i++)
            tick($urandom_range(0, 39) == 0, $urandom_range(0, 7), 1'($urandom),
                 RES_EN && $urandom_range(0, 5) == 0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
